// File: rtl/viterbi_chan_pkg.sv
// rtl/viterbi_chan_pkg.sv - shared types, constants and helpers for the Viterbi test channel
//
// Contents:
//   chan_mode_t        error-injection mode carried on mode_i
//   LFSR_TAPS_DEFAULT  Galois tap mask for x^32+x^22+x^2+x+1 (right-shifting form)
//   popcount()         number of set bits in a mask; masks up to 64 bits wide

package viterbi_chan_pkg;

    typedef enum logic [1:0] {
        CH_CLEAN  = 2'd0,
        CH_RANDOM = 2'd1,
        CH_BURST  = 2'd2,
        CH_ALL    = 2'd3
    } chan_mode_t;

    // Bit (e-1) is set for each polynomial term x^e except x^0; the state
    // shifts right and the tap mask is folded in whenever bit 0 falls out.
    localparam logic [31:0] LFSR_TAPS_DEFAULT = 32'h8020_0003;

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/chan_lfsr.sv
// rtl/chan_lfsr.sv - Galois LFSR that steps only when asked
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active low; loads SEED
//   adv_i    in   advance the register by one step this cycle
//   state_o  out  current LFSR state (LFSR_W bits)

module chan_lfsr
    import viterbi_chan_pkg::*;
#(
    parameter int                LFSR_W = 32,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(32'hACE1_2BDF),
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(LFSR_TAPS_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] state_nxt;

    always_comb begin
        state_nxt = {1'b0, state_o[LFSR_W-1:1]};
        if (state_o[0]) begin
            state_nxt = state_nxt ^ TAPS;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_o <= SEED;
        end else if (adv_i) begin
            state_o <= state_nxt;
        end
    end

endmodule

// File: rtl/viterbi_channel_model.sv
// rtl/viterbi_channel_model.sv - error-injecting channel between convolutional encoder and Viterbi decoder
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active low
//   valid_i       in   d_in carries a symbol this cycle
//   d_in          in   clean coded symbol (SYM_W bits)
//   mode_i        in   chan_mode_t: CLEAN, RANDOM, BURST, ALL
//   burst_len_i   in   burst length in symbols (0 -> 1, >BURST_MAX -> BURST_MAX)
//   inject_i      in   force a trigger on this symbol (RANDOM/BURST)
//   clr_i         in   synchronous clear of both counters
//   valid_o       out  registered valid_i
//   d_out         out  d_in ^ mask, registered; holds on idle cycles
//   err_mask_o    out  mask applied to d_out; holds on idle cycles
//   bit_err_ct_o  out  saturating count of flipped bits
//   sym_ct_o      out  saturating count of output symbols

module viterbi_channel_model
    import viterbi_chan_pkg::*;
#(
    parameter int                SYM_W     = 2,
    parameter int                N         = 3,
    parameter int                LFSR_W    = 32,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(32'hACE1_2BDF),
    parameter int                BURST_MAX = 8,
    parameter int                CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_i,
    input  logic [SYM_W-1:0]               d_in,
    input  logic [1:0]                     mode_i,
    input  logic [$clog2(BURST_MAX+1)-1:0] burst_len_i,
    input  logic                           inject_i,
    input  logic                           clr_i,
    output logic                           valid_o,
    output logic [SYM_W-1:0]               d_out,
    output logic [SYM_W-1:0]               err_mask_o,
    output logic [CNT_W-1:0]               bit_err_ct_o,
    output logic [CNT_W-1:0]               sym_ct_o
);

    localparam int               BL_W    = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    chan_mode_t        mode;
    logic [LFSR_W-1:0] lfsr;
    logic              trig;
    logic [SYM_W-1:0]  rnd_field;
    logic [SYM_W-1:0]  mask;
    logic [BL_W-1:0]   len_eff;
    logic [BL_W-1:0]   burst_cnt;
    logic [BL_W-1:0]   burst_nxt;
    logic [CNT_W:0]    bit_sum;
    logic [CNT_W:0]    sym_sum;

    assign mode = chan_mode_t'(mode_i);

    // The LFSR steps once per accepted symbol, so the error sequence depends
    // only on the number of symbols seen, not on gaps in valid_i.
    chan_lfsr #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED),
        .TAPS   (LFSR_W'(LFSR_TAPS_DEFAULT))
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (valid_i),
        .state_o (lfsr)
    );

    // Trigger and mask come from the pre-advance state.
    assign trig      = inject_i | (&lfsr[N-1:0]);
    assign rnd_field = lfsr[N +: SYM_W];

    always_comb begin
        if (burst_len_i == '0) begin
            len_eff = BL_W'(1);
        end else if (burst_len_i > BL_W'(BURST_MAX)) begin
            len_eff = BL_W'(BURST_MAX);
        end else begin
            len_eff = burst_len_i;
        end
    end

    // burst_cnt counts symbols still to corrupt after the current one; while
    // it is nonzero further triggers are ignored, so a burst never extends.
    always_comb begin
        mask      = '0;
        burst_nxt = '0;
        case (mode)
            CH_RANDOM: begin
                if (trig) begin
                    // A trigger must flip something even when the field is zero.
                    mask = (rnd_field == '0) ? SYM_W'(1) : rnd_field;
                end
            end
            CH_BURST: begin
                if (burst_cnt != '0) begin
                    mask      = '1;
                    burst_nxt = burst_cnt - BL_W'(1);
                end else if (trig) begin
                    mask      = '1;
                    burst_nxt = len_eff - BL_W'(1);
                end
            end
            CH_ALL: begin
                mask = '1;
            end
            default: begin
                mask = '0;
            end
        endcase
    end

    // Any edge outside BURST mode aborts a burst in progress, even an idle one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_cnt <= '0;
        end else if (mode != CH_BURST) begin
            burst_cnt <= '0;
        end else if (valid_i) begin
            burst_cnt <= burst_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o    <= 1'b0;
            d_out      <= '0;
            err_mask_o <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                d_out      <= d_in ^ mask;
                err_mask_o <= mask;
            end
        end
    end

    // Counters track the registered output, so they lag valid_o by one cycle.
    assign bit_sum = {1'b0, bit_err_ct_o} + (CNT_W+1)'(popcount(64'(err_mask_o)));
    assign sym_sum = {1'b0, sym_ct_o} + (CNT_W+1)'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_err_ct_o <= '0;
            sym_ct_o     <= '0;
        end else if (clr_i) begin
            bit_err_ct_o <= '0;
            sym_ct_o     <= '0;
        end else if (valid_o) begin
            bit_err_ct_o <= bit_sum[CNT_W] ? CNT_MAX : bit_sum[CNT_W-1:0];
            sym_ct_o     <= sym_sum[CNT_W] ? CNT_MAX : sym_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_viterbi_channel_model.sv
// tb/tb_viterbi_channel_model.sv - self-checking bench for viterbi_channel_model

module tb_viterbi_channel_model;

    localparam int M_CLEAN  = 0;
    localparam int M_RANDOM = 1;
    localparam int M_BURST  = 2;
    localparam int M_ALL    = 3;
    localparam bit [31:0] TB_SEED = 32'hACE1_2BDF;
    // taps derived from x^32+x^22+x^2+x+1: bit (e-1) for each term e>0
    localparam bit [31:0] TB_TAPS = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_i;
    logic [1:0] d_in;
    logic [1:0] mode_i;
    logic [3:0] burst_len_i;
    logic       inject_i;
    logic       clr_i;

    logic        vo_a, vo_b;
    logic [1:0]  d_a, d_b, m_a, m_b;
    logic [15:0] bc_a, sc_a;
    logic [3:0]  bc_b, sc_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    viterbi_channel_model dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .d_in(d_in), .mode_i(mode_i),
        .burst_len_i(burst_len_i), .inject_i(inject_i), .clr_i(clr_i),
        .valid_o(vo_a), .d_out(d_a), .err_mask_o(m_a),
        .bit_err_ct_o(bc_a), .sym_ct_o(sc_a)
    );

    viterbi_channel_model #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .valid_i(valid_i), .d_in(d_in), .mode_i(mode_i),
        .burst_len_i(burst_len_i), .inject_i(inject_i), .clr_i(clr_i),
        .valid_o(vo_b), .d_out(d_b), .err_mask_o(m_b),
        .bit_err_ct_o(bc_b), .sym_ct_o(sc_b)
    );

    // ---------------- reference model ----------------
    bit [31:0] m_lfsr;
    int        m_burst_left;
    int        m_bit, m_sym;
    bit        m_vo;
    bit [1:0]  m_mask, m_d;

    function automatic bit [31:0] lfsr_next(input bit [31:0] s);
        return s[0] ? ((s >> 1) ^ TB_TAPS) : (s >> 1);
    endfunction

    function automatic bit clear_ahead(input bit [31:0] s, input int k);
        bit [31:0] t;
        t = s;
        for (int i = 0; i < k; i++) begin
            if ((t & 32'd7) == 32'd7) return 1'b0;
            t = lfsr_next(t);
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_lfsr = TB_SEED; m_burst_left = 0; m_bit = 0; m_sym = 0;
        m_vo = 0; m_mask = 0; m_d = 0;
    endtask

    task automatic model_step(input bit v, input bit [1:0] d, input int mode,
                              input bit inj, input int blen, input bit clr);
        bit       trig;
        bit [1:0] mk, f;
        int       len;
        if (clr) begin
            m_bit = 0; m_sym = 0;
        end else if (m_vo) begin
            m_bit = (m_bit + $countones(m_mask) > 65535) ? 65535 : m_bit + $countones(m_mask);
            m_sym = (m_sym + 1 > 65535) ? 65535 : m_sym + 1;
        end
        if (v) begin
            trig = inj || ((m_lfsr & 32'd7) == 32'd7);
            f    = 2'((m_lfsr >> 3) & 32'd3);
            mk   = 2'b00;
            if (mode == M_RANDOM && trig) mk = (f == 2'b00) ? 2'b01 : f;
            if (mode == M_ALL) mk = 2'b11;
            if (mode == M_BURST) begin
                if (m_burst_left > 0) begin
                    mk = 2'b11; m_burst_left--;
                end else if (trig) begin
                    len = (blen == 0) ? 1 : ((blen > 8) ? 8 : blen);
                    mk = 2'b11; m_burst_left = len - 1;
                end
            end
            m_lfsr = lfsr_next(m_lfsr);
            m_vo = 1; m_mask = mk; m_d = d ^ mk;
        end else begin
            m_vo = 0;
        end
        if (mode != M_BURST) m_burst_left = 0;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit [1:0] d, input int mode,
                         input bit inj, input int blen, input bit clr);
        valid_i = v; d_in = d; mode_i = 2'(mode); inject_i = inj;
        burst_len_i = 4'(blen); clr_i = clr;
        model_step(v, d, mode, inj, blen, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("rst_vo", 64'(vo_a), 0);
        chk("rst_d", 64'(d_a), 0);
        chk("rst_mask", 64'(m_a), 0);
        chk("rst_bitct", 64'(bc_a), 0);
        chk("rst_symct", 64'(sc_a), 0);
        @(posedge clk);
        #3 rst = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int       win;
        int       mode;
        bit       v;
        bit [1:0] d;
        bit       inj;
        int       blen;
        bit       clr;
        bit       chk_out;
        bit       e_vo;
        bit [1:0] e_mask;
        bit [1:0] e_d;
        bit       chk_ct;
        int       e_bit;
        int       e_sym;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int win, input int mode, input bit v, input bit [1:0] d,
                                input bit inj, input int blen, input bit clr,
                                input bit co, input bit evo, input bit [1:0] em, input bit [1:0] ed,
                                input bit cc, input int eb, input int es);
        vec_t r;
        r.win = win; r.mode = mode; r.v = v; r.d = d; r.inj = inj; r.blen = blen; r.clr = clr;
        r.chk_out = co; r.e_vo = evo; r.e_mask = em; r.e_d = ed;
        r.chk_ct = cc; r.e_bit = eb; r.e_sym = es;
        return r;
    endfunction

    bit       st_v[$];
    bit [1:0] st_d[$];
    bit [1:0] rec[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit [1:0] d;
        int       nvalid, ntrig, ridx, frac_milli, guard;

        rst = 1'b0; valid_i = 0; d_in = 0; mode_i = 0; burst_len_i = 0; inject_i = 0; clr_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst0_vo", 64'(vo_a), 0);
        chk("rst0_mask", 64'(m_a), 0);
        chk("rst0_bitct_s", 64'(bc_b), 0);
        #2 rst = 1'b1;

        // CLEAN: 100 symbols pass through untouched
        for (int i = 0; i < 100; i++) begin
            d = 2'($urandom);
            drive(1, d, M_CLEAN, 0, 0, 0);
            chk("clean_vo", 64'(vo_a), 1);
            chk("clean_d", 64'(d_a), 64'(d));
            chk("clean_mask", 64'(m_a), 0);
        end
        drive(0, 0, M_CLEAN, 0, 0, 0);
        chk("clean_bitct", 64'(bc_a), 0);
        chk("clean_symct", 64'(sc_a), 100);
        chk("clean_symct_sat4", 64'(sc_b), 15);

        // table: ALL counts, burst retrigger, clamp, len 0, abort
        tbl.push_back(mk(0, M_CLEAN, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, M_ALL, 1, 2'b01, 0, 0, 0, 1, 1, 2'b11, 2'b10, 0, 0, 0));
        tbl.push_back(mk(0, M_ALL, 0, 2'b01, 0, 0, 0, 1, 0, 2'b11, 2'b10, 1, 10, 5));
        tbl.push_back(mk(8, M_BURST, 1, 2'b00, 0, 3, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, M_BURST, 1, 2'b11, 0, 3, 0, 1, 1, 2'b00, 2'b11, 0, 0, 0));
        tbl.push_back(mk(0, M_BURST, 1, 2'b01, 1, 3, 0, 1, 1, 2'b11, 2'b10, 0, 0, 0));
        tbl.push_back(mk(0, M_BURST, 1, 2'b10, 1, 3, 0, 1, 1, 2'b11, 2'b01, 0, 0, 0));
        tbl.push_back(mk(0, M_BURST, 1, 2'b11, 0, 3, 0, 1, 1, 2'b11, 2'b00, 0, 0, 0));
        tbl.push_back(mk(0, M_BURST, 1, 2'b01, 0, 3, 0, 1, 1, 2'b00, 2'b01, 0, 0, 0));
        tbl.push_back(mk(10, M_BURST, 1, 2'b00, 1, 15, 0, 1, 1, 2'b11, 2'b11, 0, 0, 0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(0, M_BURST, 1, 2'b00, 0, 15, 0, 1, 1, 2'b11, 2'b11, 0, 0, 0));
        tbl.push_back(mk(0, M_BURST, 1, 2'b10, 0, 15, 0, 1, 1, 2'b00, 2'b10, 0, 0, 0));
        tbl.push_back(mk(0, M_BURST, 0, 2'b01, 0, 15, 0, 1, 0, 2'b00, 2'b10, 0, 0, 0));
        tbl.push_back(mk(3, M_BURST, 1, 2'b11, 1, 0, 0, 1, 1, 2'b11, 2'b00, 0, 0, 0));
        tbl.push_back(mk(0, M_BURST, 1, 2'b11, 0, 0, 0, 1, 1, 2'b00, 2'b11, 0, 0, 0));
        tbl.push_back(mk(0, M_BURST, 1, 2'b11, 0, 0, 0, 1, 1, 2'b00, 2'b11, 0, 0, 0));
        tbl.push_back(mk(4, M_BURST, 1, 2'b00, 1, 8, 0, 1, 1, 2'b11, 2'b11, 0, 0, 0));
        tbl.push_back(mk(0, M_BURST, 1, 2'b00, 0, 8, 0, 1, 1, 2'b11, 2'b11, 0, 0, 0));
        tbl.push_back(mk(0, M_CLEAN, 1, 2'b00, 0, 8, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(mk(0, M_BURST, 1, 2'b00, 0, 8, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].win > 0) begin
                // step CLEAN symbols until no natural trigger lies in the window
                guard = 0;
                while (!clear_ahead(m_lfsr, tbl[i].win) && guard < 300) begin
                    drive(1, 0, M_CLEAN, 0, 0, 0);
                    guard++;
                end
                chk($sformatf("tbl%0d_window_found", i), 64'(guard < 300), 1);
            end
            drive(tbl[i].v, tbl[i].d, tbl[i].mode, tbl[i].inj, tbl[i].blen, tbl[i].clr);
            if (tbl[i].chk_out) begin
                chk($sformatf("tbl%0d_vo", i), 64'(vo_a), 64'(tbl[i].e_vo));
                chk($sformatf("tbl%0d_mask", i), 64'(m_a), 64'(tbl[i].e_mask));
                chk($sformatf("tbl%0d_d", i), 64'(d_a), 64'(tbl[i].e_d));
            end
            if (tbl[i].chk_ct) begin
                chk($sformatf("tbl%0d_bitct", i), 64'(bc_a), 64'(tbl[i].e_bit));
                chk($sformatf("tbl%0d_symct", i), 64'(sc_a), 64'(tbl[i].e_sym));
            end
        end

        // saturation on the CNT_W=4 instance, then clear colliding with an update
        drive(0, 0, M_ALL, 0, 0, 1);
        for (int i = 0; i < 9; i++) drive(1, 2'($urandom), M_ALL, 0, 0, 0);
        drive(0, 0, M_ALL, 0, 0, 0);
        chk("sat_bitct_s", 64'(bc_b), 15);
        chk("sat_symct_s", 64'(sc_b), 9);
        chk("sat_bitct", 64'(bc_a), 18);
        chk("sat_symct", 64'(sc_a), 9);
        drive(1, 2'b01, M_ALL, 0, 0, 0);
        drive(1, 2'b01, M_ALL, 0, 0, 1);
        chk("clr_bitct", 64'(bc_a), 0);
        chk("clr_symct", 64'(sc_a), 0);
        chk("clr_bitct_s", 64'(bc_b), 0);
        chk("clr_symct_s", 64'(sc_b), 0);
        drive(0, 0, M_ALL, 0, 0, 0);
        chk("postclr_bitct", 64'(bc_a), 64'(m_bit));
        chk("postclr_symct", 64'(sc_a), 64'(m_sym));

        // RANDOM run with gaps, checked against the model
        nvalid = 0;
        while (nvalid < 4096) begin
            st_v.push_back($urandom_range(0, 3) != 0);
            st_d.push_back(2'($urandom));
            if (st_v[st_v.size()-1]) nvalid++;
        end
        do_reset();
        ntrig = 0;
        for (int i = 0; i < st_v.size(); i++) begin
            drive(st_v[i], st_d[i], M_RANDOM, 0, 0, 0);
            if (st_v[i]) begin
                chk("rnd_mask", 64'(m_a), 64'(m_mask));
                chk("rnd_d", 64'(d_a), 64'(m_d));
                rec.push_back(m_mask);
                if (m_mask != 2'b00) ntrig++;
            end else begin
                chk("rnd_idle_vo", 64'(vo_a), 0);
            end
        end
        drive(0, 0, M_RANDOM, 0, 0, 0);
        chk("rnd_symct", 64'(sc_a), 4096);
        frac_milli = ntrig * 1000 / 4096;
        n_cmp++;
        if (frac_milli < 105 || frac_milli > 145) begin
            n_bad++;
            $display("FAIL rnd_trigger_fraction: got %0d/1000 required 105..145", frac_milli);
        end

        // reset in the middle of a burst, then replay the same stimulus
        drive(1, 0, M_BURST, 1, 8, 0);
        drive(1, 0, M_BURST, 0, 8, 0);
        chk("midburst_mask", 64'(m_a), 3);
        do_reset();
        ridx = 0;
        for (int i = 0; i < st_v.size(); i++) begin
            drive(st_v[i], st_d[i], M_RANDOM, 0, 0, 0);
            if (st_v[i]) begin
                chk("replay_mask", 64'(m_a), 64'(rec[ridx]));
                ridx++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
